frac_search_grid: RTL and testbench

- Parametrised fractional-pel motion search.
- Streams one row of interpolated candidate pixels plus the matching reference row per accepted beat.
- Accumulates SAD per candidate over a GRIDxGRID candidate grid and reports the best candidate's MV and SAD.
- Sits after the interpolation filter and before mode decision; generalises the fixed 8-pixel, single-shot search to any row width, block height and grid size, with valid/ready flow control on both sides.

---
 rtl/frac_search_pkg.sv | 56 +++++
 rtl/sad_row.sv | 39 +++
 rtl/frac_search_grid.sv | 181 ++++++++++++++++++
 tb/tb_frac_search_grid.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/frac_search_pkg.sv
// Shared definitions for the fractional-pel motion search block.
// Holds the FSM state encoding, a constant clog2, width-derivation helpers
// and the candidate-index to motion-vector mapping.
package frac_search_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    for (r = 0; (64'd1 << r) < 64'(v); r++) begin
    end
    return r;
  endfunction

  // Counters need at least one bit even when they only ever hold zero.
  function automatic int unsigned max1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  // Width of the per-row SAD: worst case (2^pix_w - 1) * npix.
  function automatic int unsigned row_sad_width(input int unsigned pix_w,
                                                input int unsigned npix);
    return pix_w + clog2(npix);
  endfunction

  // Width of the per-candidate accumulator: worst case (2^pix_w - 1) * npix * rows.
  function automatic int unsigned acc_width(input int unsigned pix_w,
                                            input int unsigned npix,
                                            input int unsigned rows);
    return pix_w + clog2(npix * rows);
  endfunction

  // Candidate index k maps to column (k mod grid) and row (k div grid),
  // both centred on the grid middle.
  function automatic int idx_to_mvx(input int idx, input int grid);
    return (idx % grid) - (grid - 1) / 2;
  endfunction

  function automatic int idx_to_mvy(input int idx, input int grid);
    return (idx / grid) - (grid - 1) / 2;
  endfunction

  // L1 norm of the motion vector for candidate idx.
  function automatic int unsigned mv_l1(input int idx, input int grid);
    int mx;
    int my;
    mx = idx_to_mvx(idx, grid);
    my = idx_to_mvy(idx, grid);
    return int'((mx < 0) ? -mx : mx) + int'((my < 0) ? -my : my);
  endfunction

endpackage

// File: rtl/sad_row.sv
// Combinational sum of absolute differences across one row of pixels.
// Ports:
//   cand_i : NPIX candidate pixels, pixel i at [i*PIX_W +: PIX_W]
//   ref_i  : NPIX reference pixels, same packing
//   sad_o  : sum over i of |cand_i - ref_i|, PIX_W + clog2(NPIX) bits
module sad_row
  import frac_search_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 8,
  localparam int unsigned OutW = row_sad_width(PIX_W, NPIX)
) (
  input  logic [NPIX*PIX_W-1:0] cand_i,
  input  logic [NPIX*PIX_W-1:0] ref_i,
  output logic [OutW-1:0]       sad_o
);

  // Absolute differences, one per pixel lane.
  logic [PIX_W-1:0] diff [NPIX];

  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      if (cand_i[i*PIX_W +: PIX_W] > ref_i[i*PIX_W +: PIX_W]) begin
        diff[i] = cand_i[i*PIX_W +: PIX_W] - ref_i[i*PIX_W +: PIX_W];
      end else begin
        diff[i] = ref_i[i*PIX_W +: PIX_W] - cand_i[i*PIX_W +: PIX_W];
      end
    end
  end

  // Output width covers the all-lanes-maximum case, so the sum cannot wrap.
  always_comb begin
    sad_o = '0;
    for (int i = 0; i < NPIX; i++) begin
      sad_o = sad_o + OutW'(diff[i]);
    end
  end

endmodule

// File: rtl/frac_search_grid.sv
// Fractional-pel motion search over a GRID x GRID candidate grid.
// Accepts one row of interpolated candidate pixels plus the matching
// reference row per beat, candidate-major (ROWS beats per candidate),
// accumulates SAD per candidate and reports the lowest-cost candidate.
// Optional build macro: FRAC_SEARCH_MVCOST_EN adds LAMBDA*(|mvx|+|mvy|)
// to each candidate's cost before comparison and widens best_sad_o by 1.
// Ports:
//   clk_i, rst_ni   : clock (rising edge), asynchronous active-low reset
//   filter_pix_i    : candidate row, pixel i at [i*PIX_W +: PIX_W]
//   ref_pix_i       : reference row, same packing
//   in_valid_i/in_ready_o   : input beat handshake
//   mvx_o, mvy_o    : signed best motion vector
//   best_sad_o      : best candidate cost
//   best_idx_o      : best candidate index
//   out_valid_o/out_ready_i : result handshake
module frac_search_grid
  import frac_search_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned NPIX   = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned GRID   = 3,
  parameter int unsigned MV_W   = 3,
  parameter int unsigned LAMBDA = 4,
  localparam int unsigned NCAND = GRID * GRID,
  localparam int unsigned AccW  = acc_width(PIX_W, NPIX, ROWS),
`ifdef FRAC_SEARCH_MVCOST_EN
  localparam int unsigned SW    = AccW + 1,
`else
  localparam int unsigned SW    = AccW,
`endif
  localparam int unsigned IdxW  = max1(clog2(NCAND))
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NPIX*PIX_W-1:0]   filter_pix_i,
  input  logic [NPIX*PIX_W-1:0]   ref_pix_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [MV_W-1:0]         mvx_o,
  output logic [MV_W-1:0]         mvy_o,
  output logic [SW-1:0]           best_sad_o,
  output logic [IdxW-1:0]         best_idx_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  localparam int unsigned RowW    = max1(clog2(ROWS));
  localparam int unsigned RowSadW = row_sad_width(PIX_W, NPIX);

  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);
  localparam logic [IdxW-1:0] LastCand = IdxW'(NCAND - 1);

  // Elaboration-time parameter sanity.
  if (GRID % 2 == 0) begin : g_chk_grid
    $error("GRID must be odd");
  end
  if ((GRID - 1) / 2 > (1 << (MV_W - 1)) - 1) begin : g_chk_mvw
    $error("MV_W too narrow for GRID");
  end
  if (LAMBDA * (GRID - 1) > (1 << AccW)) begin : g_chk_lambda
    $error("LAMBDA too large for one extra cost bit");
  end

  logic [1:0]      state_q, state_d;
  logic [RowW-1:0] row_q, row_d;
  logic [IdxW-1:0] cand_q, cand_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [SW-1:0]   best_sad_q, best_sad_d;
  logic [IdxW-1:0] best_idx_q, best_idx_d;
  logic [MV_W-1:0] mvx_q, mvx_d;
  logic [MV_W-1:0] mvy_q, mvy_d;

  logic [RowSadW-1:0] row_sad;
  logic [AccW-1:0]    cand_sum;
  logic [SW-1:0]      cand_cost;
  logic [MV_W-1:0]    cand_mvx, cand_mvy;
  logic               accept;
  logic               last_row, last_cand, better;

  sad_row #(
    .PIX_W (PIX_W),
    .NPIX  (NPIX)
  ) u_sad_row (
    .cand_i (filter_pix_i),
    .ref_i  (ref_pix_i),
    .sad_o  (row_sad)
  );

  // Ready is forced low while reset is asserted, not just after it.
  assign in_ready_o  = rst_ni && (state_q != StDone);
  assign out_valid_o = (state_q == StDone);
  assign accept      = in_valid_i && in_ready_o;

  assign last_row  = (row_q == LastRow);
  assign last_cand = (cand_q == LastCand);
  assign cand_sum  = acc_q + AccW'(row_sad);
  assign cand_mvx  = MV_W'(idx_to_mvx(int'(cand_q), int'(GRID)));
  assign cand_mvy  = MV_W'(idx_to_mvy(int'(cand_q), int'(GRID)));

`ifdef FRAC_SEARCH_MVCOST_EN
  assign cand_cost = SW'(cand_sum) + SW'(LAMBDA * mv_l1(int'(cand_q), int'(GRID)));
`else
  assign cand_cost = cand_sum;
`endif

  // Candidate 0 always loads; strict less-than keeps the lower index on ties.
  assign better = (cand_q == '0) || (cand_cost < best_sad_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_d     = cand_q;
    acc_d      = acc_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    mvx_d      = mvx_q;
    mvy_d      = mvy_q;

    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          state_d = StAccum;
          if (last_row) begin
            acc_d = '0;
            row_d = '0;
            if (better) begin
              best_sad_d = cand_cost;
              best_idx_d = cand_q;
              mvx_d      = cand_mvx;
              mvy_d      = cand_mvy;
            end
            if (last_cand) begin
              cand_d  = '0;
              state_d = StDone;
            end else begin
              cand_d = cand_q + 1'b1;
            end
          end else begin
            acc_d = cand_sum;
            row_d = row_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      row_q      <= '0;
      cand_q     <= '0;
      acc_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      mvx_q      <= '0;
      mvy_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      mvx_q      <= mvx_d;
      mvy_q      <= mvy_d;
    end
  end

  assign mvx_o      = mvx_q;
  assign mvy_o      = mvy_q;
  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: tb/tb_frac_search_grid.sv
// Directed bench for frac_search_grid at default parameters
// (PIX_W=8, NPIX=8, ROWS=4, GRID=3, MV_W=3, LAMBDA=4).
module tb_frac_search_grid;

`ifdef FRAC_SEARCH_MVCOST_EN
  localparam int SW = 14;
`else
  localparam int SW = 13;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   filter_pix = '0;
  logic [63:0]   ref_pix = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    mvx;
  logic [2:0]    mvy;
  logic [SW-1:0] best_sad;
  logic [3:0]    best_idx;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  frac_search_grid dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .filter_pix_i (filter_pix),
    .ref_pix_i    (ref_pix),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .mvx_o        (mvx),
    .mvy_o        (mvy),
    .best_sad_o   (best_sad),
    .best_idx_o   (best_idx),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scenario 1 is the saturated stress case (ref all zero); others use a
  // varied reference pattern that never exceeds 0xFE so ref+1 cannot wrap.
  function automatic logic [63:0] ref_row(input int scn, input int r);
    logic [63:0] v;
    v = '0;
    if (scn != 1) begin
      for (int p = 0; p < 8; p++) v[p*8 +: 8] = 8'((r * 40 + p * 20) % 200);
    end
    return v;
  endfunction

  // exact: candidate identical to ref (scn 0/2) or at 0xFE (scn 1).
  // scn 2: candidate 4 differs from ref by 6 in one pixel only.
  function automatic logic [63:0] cand_row(input int scn, input int exact, input int c,
                                           input int r);
    logic [63:0] v;
    v = ref_row(scn, r);
    if (scn == 1) begin
      v = (c == exact) ? {8{8'hFE}} : {8{8'hFF}};
    end else if (c != exact) begin
      if (scn == 2 && c == 4) begin
        if (r == 0) v[7:0] = v[7:0] + 8'd6;
      end else begin
        for (int p = 0; p < 8; p++) v[p*8 +: 8] = v[p*8 +: 8] + 8'd1;
      end
    end
    return v;
  endfunction

  // Called just after a rising edge; returns #1 after the accepting edge.
  task automatic do_beat(input logic [63:0] f, input logic [63:0] r);
    int n;
    n = 0;
    filter_pix = f;
    ref_pix    = r;
    in_valid   = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int scn, input int exact, input int nbeats, input bit bubbles);
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      if (b == 35) check("pre_last_out_valid", 32'(out_valid), 32'd0);
      do_beat(cand_row(scn, exact, b / 4, b % 4), ref_row(scn, b % 4));
    end
    // Result must appear exactly one cycle after the final accepted beat.
    if (nbeats == 36) check("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input int idx, input int mx, input int my,
                              input int sad);
    check({tag, "_idx"}, 32'(best_idx), 32'(idx));
    check({tag, "_mvx"}, 32'(mvx), 32'(mx));
    check({tag, "_mvy"}, 32'(mvy), 32'(my));
    check({tag, "_sad"}, 32'(best_sad), 32'(sad));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // MV encodings (3-bit two's complement): -1 = 7, 0 = 0, +1 = 1.
  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_result("rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Only candidate 5 matches exactly.
    send_block(0, 5, 36, 1'b0);
    check_result("s1", 5, 1, 0, 0);
    handshake();

    // All candidates tie at 32; lowest index wins.
    send_block(0, -1, 36, 1'b0);
    check_result("tie", 0, 7, 7, 32);
    handshake();

    // Saturated pixels: 255*32 = 8160 everywhere except cand 8 at 254*32 = 8128.
    send_block(1, 8, 36, 1'b0);
    check_result("max", 8, 1, 1, 8128);

    // Back-pressure: junk beats offered while the result is held.
    filter_pix = '1;
    ref_pix    = '0;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_idx", 32'(best_idx), 32'd8);
      check("hold_sad", 32'(best_sad), 32'd8128);
    end
    in_valid = 1'b0;
    handshake();
    check("after_hs_idx", 32'(best_idx), 32'd8);
    check("after_hs_sad", 32'(best_sad), 32'd8128);

    send_block(0, 4, 36, 1'b0);
    check_result("s4", 4, 0, 0, 0);
    handshake();

    // Random input bubbles on scenario-1 data.
    send_block(0, 5, 36, 1'b1);
    check_result("bubble", 5, 1, 0, 0);
    handshake();

    // Reset with cand 3 row 2 next; cands 0..2 (all 32) have loaded best idx 0.
    send_block(0, 5, 14, 1'b0);
    check_result("pre_rst", 0, 7, 7, 32);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_result("mid_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_block(0, 5, 36, 1'b0);
    check_result("post_rst", 5, 1, 0, 0);
    handshake();

    // Cand 0 exact (SAD 0), cand 4 SAD 6, others SAD 32.
    send_block(2, 0, 36, 1'b0);
`ifdef FRAC_SEARCH_MVCOST_EN
    // Cand 0 costs 0 + 4*2 = 8; cand 4 costs 6 + 0 = 6.
    check_result("mvcost", 4, 0, 0, 6);
`else
    check_result("mvcost", 0, 7, 7, 0);
`endif
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
